// File: rtl/pkt_arb.sv
// pkt_arb: two-input packet arbiter. Each requester feeds a 4-deep
// fall-through FIFO; the output is granted to one requester for a whole
// packet (header words ctrl!=0, data words ctrl==0, EOP word ctrl!=0).
//
// Handshake: a requester may write while its rdy is high (FIFO not nearly
// full); a write into a full FIFO is dropped. A word is transferred
// downstream in every cycle where out_wr=1, which only happens when
// out_rdy=1. There is no back-pressure beyond out_rdy.
//
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   in0_*/in1_*             requester data/ctrl/write strobe, rdy back
//   out_data/out_ctrl/out_wr merged stream (data/ctrl forced to 0 when idle)
//   out_rdy                 downstream ready
//   grant                   01 = SEND0, 10 = SEND1, 00 = IDLE
//   pkt_done0/pkt_done1     pulse with the EOP word of in0/in1
//   dbg_state               current FSM state (0 IDLE, 1 SEND0, 2 SEND1)
//
// Configuration: define PKT_ARB_STRICT_PRIO_EN to make in0 always win the
// selection in IDLE; otherwise selection is round-robin on ties.

module pkt_arb_fifo #(
  parameter int W = 72
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [W-1:0] wdata,
  input  logic         wr,
  input  logic         rd,
  output logic [W-1:0] head,
  output logic         empty,
  output logic         nearly_full
);
  logic [W-1:0] mem [4];
  logic [1:0]   wp;
  logic [1:0]   rp;
  logic [2:0]   cnt;
  logic         push;
  logic         pop;

  assign push        = wr && (cnt != 3'd4);
  assign pop         = rd && (cnt != 3'd0);
  assign head        = mem[rp];
  assign empty       = (cnt == 3'd0);
  assign nearly_full = (cnt >= 3'd3);

  always_ff @(posedge clk) begin
    if (push) mem[wp] <= wdata;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (push) wp <= wp + 2'd1;
      if (pop)  rp <= rp + 2'd1;
      case ({push, pop})
        2'b10:   cnt <= cnt + 3'd1;
        2'b01:   cnt <= cnt - 3'd1;
        default: cnt <= cnt;
      endcase
    end
  end
endmodule

module pkt_arb #(
  parameter int DATA_WIDTH = 64,
  parameter int CTRL_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [DATA_WIDTH-1:0] in0_data,
  input  logic [CTRL_WIDTH-1:0] in0_ctrl,
  input  logic                  in0_wr,
  output logic                  in0_rdy,
  input  logic [DATA_WIDTH-1:0] in1_data,
  input  logic [CTRL_WIDTH-1:0] in1_ctrl,
  input  logic                  in1_wr,
  output logic                  in1_rdy,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [CTRL_WIDTH-1:0] out_ctrl,
  output logic                  out_wr,
  input  logic                  out_rdy,
  output logic [1:0]            grant,
  output logic                  pkt_done0,
  output logic                  pkt_done1,
  output logic [1:0]            dbg_state
);
  localparam int W = DATA_WIDTH + CTRL_WIDTH;

  typedef enum logic [1:0] {IDLE = 2'd0, SEND0 = 2'd1, SEND1 = 2'd2} state_t;

  state_t          state;
  logic            seen_data;
  logic [W-1:0]    head0, head1;
  logic            empty0, empty1;
  logic            nf0, nf1;
  logic            pop0, pop1;
  logic            sel;
  logic            src;
  logic            fwd;
  logic            is_eop;
  logic [DATA_WIDTH-1:0] head_data;
  logic [CTRL_WIDTH-1:0] head_ctrl;
`ifndef PKT_ARB_STRICT_PRIO_EN
  logic            last_grant;
`endif

  pkt_arb_fifo #(.W(W)) u_fifo0 (
    .clk(clk), .reset_n(reset_n), .wdata({in0_ctrl, in0_data}), .wr(in0_wr),
    .rd(pop0), .head(head0), .empty(empty0), .nearly_full(nf0)
  );

  pkt_arb_fifo #(.W(W)) u_fifo1 (
    .clk(clk), .reset_n(reset_n), .wdata({in1_ctrl, in1_data}), .wr(in1_wr),
    .rd(pop1), .head(head1), .empty(empty1), .nearly_full(nf1)
  );

  assign in0_rdy = !nf0;
  assign in1_rdy = !nf1;

  // Input chosen when leaving IDLE.
  always_comb begin
`ifdef PKT_ARB_STRICT_PRIO_EN
    sel = empty0;
`else
    if (!empty0 && !empty1) sel = ~last_grant;
    else                    sel = empty0;
`endif
  end

  always_comb begin
    fwd = 1'b0;
    src = 1'b0;
    case (state)
      IDLE:    begin fwd = out_rdy && !(empty0 && empty1); src = sel;  end
      SEND0:   begin fwd = out_rdy && !empty0;             src = 1'b0; end
      SEND1:   begin fwd = out_rdy && !empty1;             src = 1'b1; end
      default: begin fwd = 1'b0;                           src = 1'b0; end
    endcase
  end

  assign {head_ctrl, head_data} = src ? head1 : head0;

  // The first word of a grant is forwarded from IDLE with seen_data=0, so it
  // can never be taken as EOP.
  assign is_eop = fwd && (state != IDLE) && (head_ctrl != '0) && seen_data;

  assign pop0      = fwd && !src;
  assign pop1      = fwd && src;
  assign out_wr    = fwd;
  assign out_data  = fwd ? head_data : '0;
  assign out_ctrl  = fwd ? head_ctrl : '0;
  assign pkt_done0 = is_eop && (state == SEND0);
  assign pkt_done1 = is_eop && (state == SEND1);
  assign grant     = {state == SEND1, state == SEND0};
  assign dbg_state = state;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      seen_data <= 1'b0;
`ifndef PKT_ARB_STRICT_PRIO_EN
      last_grant <= 1'b1;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (fwd) begin
            state     <= src ? SEND1 : SEND0;
            // Entering SENDx clears the flag; the word forwarded now counts.
            seen_data <= (head_ctrl == '0);
`ifndef PKT_ARB_STRICT_PRIO_EN
            last_grant <= src;
`endif
          end
        end
        SEND0, SEND1: begin
          if (is_eop) begin
            state     <= IDLE;
            seen_data <= 1'b0;
          end else if (fwd && (head_ctrl == '0)) begin
            seen_data <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pkt_arb.sv
// Directed bench for pkt_arb (default round-robin build). Inputs are
// driven at the falling edge, outputs checked 1 ns later, so every check
// reflects the cycle that the next rising edge will commit.
module tb_pkt_arb;
  logic        clk;
  logic        reset_n;
  logic [63:0] in0_data, in1_data;
  logic [7:0]  in0_ctrl, in1_ctrl;
  logic        in0_wr, in1_wr;
  logic        in0_rdy, in1_rdy;
  logic [63:0] out_data;
  logic [7:0]  out_ctrl;
  logic        out_wr;
  logic        out_rdy;
  logic [1:0]  grant;
  logic        pkt_done0, pkt_done1;
  logic [1:0]  dbg_state;

  int total = 0;
  int bad   = 0;

  pkt_arb #(.DATA_WIDTH(64), .CTRL_WIDTH(8)) dut (
    .clk(clk), .reset_n(reset_n),
    .in0_data(in0_data), .in0_ctrl(in0_ctrl), .in0_wr(in0_wr), .in0_rdy(in0_rdy),
    .in1_data(in1_data), .in1_ctrl(in1_ctrl), .in1_wr(in1_wr), .in1_rdy(in1_rdy),
    .out_data(out_data), .out_ctrl(out_ctrl), .out_wr(out_wr), .out_rdy(out_rdy),
    .grant(grant), .pkt_done0(pkt_done0), .pkt_done1(pkt_done1),
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Check the whole output bundle for one cycle.
  task automatic chk_out(input string tag, input logic wr, input logic [63:0] d,
                         input logic [7:0] c, input logic [1:0] g,
                         input logic d0, input logic d1);
    chk({tag, ".wr"},    64'(out_wr),    64'(wr));
    chk({tag, ".data"},  out_data,       wr ? d : 64'h0);
    chk({tag, ".ctrl"},  64'(out_ctrl),  wr ? 64'(c) : 64'h0);
    chk({tag, ".grant"}, 64'(grant),     64'(g));
    chk({tag, ".done0"}, 64'(pkt_done0), 64'(d0));
    chk({tag, ".done1"}, 64'(pkt_done1), 64'(d1));
  endtask

  // Word payload: port / packet / index packed so any reorder is visible.
  function automatic logic [63:0] wd(input int port, input int pkt, input int idx);
    return {32'(port + 32'hA0), 16'(pkt), 16'(idx)};
  endfunction

  // 4-word packet: header, data, data, EOP. 5-word: header, 3 data, EOP.
  function automatic logic [7:0] c4(input int idx);
    return (idx == 0) ? 8'hff : (idx == 3) ? 8'h01 : 8'h00;
  endfunction
  function automatic logic [7:0] c5(input int idx);
    return (idx == 0) ? 8'hff : (idx == 4) ? 8'h01 : 8'h00;
  endfunction

  // driver tasks
  task automatic drive(input int port, input logic wr, input logic [63:0] d, input logic [7:0] c);
    if (port == 0) begin in0_wr = wr; in0_data = d; in0_ctrl = c; end
    else           begin in1_wr = wr; in1_data = d; in1_ctrl = c; end
  endtask

  task automatic idle_inputs();
    drive(0, 1'b0, 64'h0, 8'h0);
    drive(1, 1'b0, 64'h0, 8'h0);
  endtask

  // Stream a 5-word packet into one port with out_rdy=1 and check it out.
  task automatic stream_pkt(input int port, input int pkt);
    logic [1:0] g;
    g = (port == 0) ? 2'b01 : 2'b10;
    for (int i = 0; i <= 6; i++) begin
      @(negedge clk);
      out_rdy = 1'b1;
      drive(port, i < 5, wd(port, pkt, i), c5(i));
      #1;
      if (i == 0)
        chk_out("stream.first", 1'b0, 64'h0, 8'h0, 2'b00, 1'b0, 1'b0);
      else if (i <= 5)
        chk_out($sformatf("stream.p%0d.w%0d", port, i - 1), 1'b1, wd(port, pkt, i - 1),
                c5(i - 1), (i == 1) ? 2'b00 : g,
                (port == 0) && (i == 5), (port == 1) && (i == 5));
      else
        chk_out("stream.after", 1'b0, 64'h0, 8'h0, 2'b00, 1'b0, 1'b0);
    end
    idle_inputs();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    idle_inputs();
    out_rdy = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0;
    out_rdy = 1'b0;
    idle_inputs();

    // reset state
    repeat (2) @(negedge clk);
    out_rdy = 1'b1;
    #1;
    chk_out("reset", 1'b0, 64'h0, 8'h0, 2'b00, 1'b0, 1'b0);
    chk("reset.state", 64'(dbg_state), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("reset.rdy0", 64'(in0_rdy), 64'd1);
    chk("reset.rdy1", 64'(in1_rdy), 64'd1);

    // single packet on in0, streamed
    stream_pkt(0, 1);

    // fill in0 with out_rdy=0, rdy drops at 3 words, 5th write is dropped
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      out_rdy = 1'b0;
      #1;
      chk($sformatf("fill.rdy%0d", i), 64'(in0_rdy), 64'(i < 3));
      drive(0, 1'b1, wd(0, 2, i), c4(i));
      #1;
      chk_out("fill.hold", 1'b0, 64'h0, 8'h0, 2'b00, 1'b0, 1'b0);
    end
    @(negedge clk);
    drive(0, 1'b1, 64'hDEAD, 8'h00);
    #1;
    chk("full.rdy", 64'(in0_rdy), 64'd0);
    for (int i = 0; i <= 4; i++) begin
      @(negedge clk);
      idle_inputs();
      out_rdy = 1'b1;
      #1;
      if (i < 4) begin
        chk($sformatf("drain.rdy%0d", i), 64'(in0_rdy), 64'(i >= 2));
        chk_out($sformatf("drain.w%0d", i), 1'b1, wd(0, 2, i), c4(i),
                (i == 0) ? 2'b00 : 2'b01, i == 3, 1'b0);
      end else begin
        chk_out("drain.lost", 1'b0, 64'h0, 8'h0, 2'b00, 1'b0, 1'b0);
      end
    end

    // both loaded, last grant was in0 -> in1 wins; out_rdy toggles during in1
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      out_rdy = 1'b0;
      drive(0, 1'b1, wd(0, 3, i), c4(i));
      drive(1, 1'b1, wd(1, 3, i), c4(i));
      #1;
      chk_out("load.hold", 1'b0, 64'h0, 8'h0, 2'b00, 1'b0, 1'b0);
    end
    for (int j = 0; j <= 6; j++) begin
      @(negedge clk);
      idle_inputs();
      out_rdy = (j % 2 == 0);
      #1;
      if (j % 2 == 0)
        chk_out($sformatf("toggle.w%0d", j / 2), 1'b1, wd(1, 3, j / 2), c4(j / 2),
                (j == 0) ? 2'b00 : 2'b10, 1'b0, j == 6);
      else
        chk_out("toggle.stall", 1'b0, 64'h0, 8'h0, 2'b10, 1'b0, 1'b0);
    end
    for (int i = 0; i <= 4; i++) begin
      @(negedge clk);
      out_rdy = 1'b1;
      #1;
      if (i < 4)
        chk_out($sformatf("rr.in0.w%0d", i), 1'b1, wd(0, 3, i), c4(i),
                (i == 0) ? 2'b00 : 2'b01, i == 3, 1'b0);
      else
        chk_out("rr.idle", 1'b0, 64'h0, 8'h0, 2'b00, 1'b0, 1'b0);
    end

    // both loaded right after reset: in0 first, then in1, no interleave
    do_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      out_rdy = 1'b0;
      drive(0, 1'b1, wd(0, 4, i), c4(i));
      drive(1, 1'b1, wd(1, 4, i), c4(i));
    end
    for (int k = 0; k <= 8; k++) begin
      @(negedge clk);
      idle_inputs();
      out_rdy = 1'b1;
      #1;
      if (k < 4)
        chk_out($sformatf("tie.in0.w%0d", k), 1'b1, wd(0, 4, k), c4(k),
                (k == 0) ? 2'b00 : 2'b01, k == 3, 1'b0);
      else if (k < 8)
        chk_out($sformatf("tie.in1.w%0d", k - 4), 1'b1, wd(1, 4, k - 4), c4(k - 4),
                (k == 4) ? 2'b00 : 2'b10, 1'b0, k == 7);
      else
        chk_out("tie.idle", 1'b0, 64'h0, 8'h0, 2'b00, 1'b0, 1'b0);
    end

    // reset in the middle of an in0 packet
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      out_rdy = 1'b1;
      drive(0, 1'b1, wd(0, 5, i), c5(i));
      #1;
      if (i > 0)
        chk_out($sformatf("mid.w%0d", i - 1), 1'b1, wd(0, 5, i - 1), c5(i - 1),
                (i == 1) ? 2'b00 : 2'b01, 1'b0, 1'b0);
    end
    @(negedge clk);
    idle_inputs();
    reset_n = 1'b0;
    #1;
    chk_out("mid.reset", 1'b0, 64'h0, 8'h0, 2'b00, 1'b0, 1'b0);
    chk("mid.state", 64'(dbg_state), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk_out("mid.flushed", 1'b0, 64'h0, 8'h0, 2'b00, 1'b0, 1'b0);
    stream_pkt(1, 6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
